// File: rtl/i2c_cfg_slave_if.sv
// Bus and register-bank signals of the I2C configuration target.
// The slave modport is the target's view; master is the pad/register-bank side.
interface i2c_cfg_slave_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy;

  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
  );

  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
  );
endinterface

// File: rtl/i2c_cfg_slave.sv
// Oversampled I2C/SCCB register target: decodes device and 16-bit register
// address, strobes register writes and serves auto-incrementing reads.
module i2c_cfg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT_LEN = 4
) (
  input logic            clk_100,
  input logic            rst_100,
  i2c_cfg_slave_if.slave bus
);
  localparam int CNT_W = $clog2(FILT_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, RAH, RAH_ACK, RAL, RAL_ACK,
    WDAT, WDAT_ACK, RDAT, RDAT_ACK
  } state_t;

  logic [1:0]       sclSync_q, sdaSync_q;
  logic             sclFilt_q, sdaFilt_q, sclPrev_q, sdaPrev_q;
  logic [CNT_W-1:0] sclCnt_q, sdaCnt_q;

  state_t      state_q;
  logic [3:0]  bitCnt_q;
  logic [7:0]  shift_q, addrHi_q;
  logic        rw_q, ackDrv_q, loadPend_q;
  logic        sda_oe_q, wr_en_q, busy_q;
  logic [15:0] wr_addr_q, rd_addr_q;
  logic [7:0]  wr_data_q;

  logic       sclRise, sclFall, startEv, stopEv;
  logic [7:0] rxByte_d;

  // A line only changes its filtered value after FILT_LEN consistent samples.
  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclFilt_q <= 1'b1;
      sdaFilt_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      sclCnt_q  <= '0;
      sdaCnt_q  <= '0;
    end else begin
      sclSync_q <= {sclSync_q[0], bus.scl_in};
      sdaSync_q <= {sdaSync_q[0], bus.sda_in};
      sclPrev_q <= sclFilt_q;
      sdaPrev_q <= sdaFilt_q;
      if (sclSync_q[1] == sclFilt_q) begin
        sclCnt_q <= '0;
      end else if (sclCnt_q == CNT_W'(FILT_LEN - 1)) begin
        sclFilt_q <= sclSync_q[1];
        sclCnt_q  <= '0;
      end else begin
        sclCnt_q <= sclCnt_q + CNT_W'(1);
      end
      if (sdaSync_q[1] == sdaFilt_q) begin
        sdaCnt_q <= '0;
      end else if (sdaCnt_q == CNT_W'(FILT_LEN - 1)) begin
        sdaFilt_q <= sdaSync_q[1];
        sdaCnt_q  <= '0;
      end else begin
        sdaCnt_q <= sdaCnt_q + CNT_W'(1);
      end
    end
  end

  assign sclRise  = sclFilt_q & ~sclPrev_q;
  assign sclFall  = ~sclFilt_q & sclPrev_q;
  assign startEv  = sclFilt_q & sclPrev_q & sdaPrev_q & ~sdaFilt_q;
  assign stopEv   = sclFilt_q & sclPrev_q & ~sdaPrev_q & sdaFilt_q;
  assign rxByte_d = {shift_q[6:0], sdaFilt_q};

  // Protocol FSM; START/STOP are checked before any bit-level activity.
  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      addrHi_q   <= '0;
      rw_q       <= 1'b0;
      ackDrv_q   <= 1'b0;
      loadPend_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (wr_en_q) rd_addr_q <= rd_addr_q + 16'd1;
      if (stopEv || startEv) begin
        state_q    <= stopEv ? IDLE : DEV;
        sda_oe_q   <= 1'b0;
        bitCnt_q   <= '0;
        ackDrv_q   <= 1'b0;
        loadPend_q <= 1'b0;
        if (stopEv) busy_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          DEV, RAH, RAL, WDAT: begin
            if (sclRise) begin
              shift_q  <= rxByte_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                bitCnt_q <= '0;
                if (state_q == DEV) begin
                  if (rxByte_d[7:1] == DEV_ADDR) begin
                    state_q <= DEV_ACK;
                    rw_q    <= rxByte_d[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= IDLE;
                  end
                end else if (state_q == RAH) begin
                  addrHi_q <= rxByte_d;
                  state_q  <= RAH_ACK;
                end else if (state_q == RAL) begin
                  rd_addr_q <= {addrHi_q, rxByte_d};
                  state_q   <= RAL_ACK;
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= rd_addr_q;
                  wr_data_q <= rxByte_d;
                  state_q   <= WDAT_ACK;
                end
              end
            end
          end
          // First SCL fall drives the ACK low, the second one ends the ACK bit.
          DEV_ACK, RAH_ACK, RAL_ACK, WDAT_ACK: begin
            if (sclFall) begin
              if (!ackDrv_q) begin
                sda_oe_q <= 1'b1;
                ackDrv_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                ackDrv_q <= 1'b0;
                case (state_q)
                  DEV_ACK: begin
                    if (rw_q) begin
                      state_q  <= RDAT;
                      shift_q  <= {bus.rd_data[6:0], 1'b0};
                      sda_oe_q <= ~bus.rd_data[7];
                    end else begin
                      state_q <= RAH;
                    end
                  end
                  RAH_ACK: state_q <= RAL;
                  default: state_q <= WDAT;
                endcase
              end
            end
          end
          RDAT: begin
            if (sclRise) bitCnt_q <= bitCnt_q + 4'd1;
            if (sclFall) begin
              if (loadPend_q) begin
                loadPend_q <= 1'b0;
                shift_q    <= {bus.rd_data[6:0], 1'b0};
                sda_oe_q   <= ~bus.rd_data[7];
              end else if (bitCnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                bitCnt_q <= '0;
                state_q  <= RDAT_ACK;
              end else begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end
          RDAT_ACK: begin
            if (sclRise) begin
              if (!sdaFilt_q) begin
                rd_addr_q  <= rd_addr_q + 16'd1;
                loadPend_q <= 1'b1;
                state_q    <= RDAT;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Directed bench for i2c_cfg_slave: a bit-banged I2C master, an open-drain SDA
// model and a register bank that returns rd_addr[7:0].
module tb_i2c_cfg_slave;
  localparam int Q = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclM = 1'b1;
  logic sdaM = 1'b1;
  logic [7:0] rdDataQ = 8'h00;

  int errors = 0;
  int checks = 0;
  int oeCount = 0;
  int wrWide = 0;
  logic wrPrev = 1'b0;
  logic [23:0] wrLog[$];

  i2c_cfg_slave_if bus ();

  i2c_cfg_slave #(.DEV_ADDR(7'h3C), .FILT_LEN(4)) dut (
    .clk_100 (clk),
    .rst_100 (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Open-drain SDA: the line is low if either side pulls it.
  assign bus.scl_in  = sclM;
  assign bus.sda_in  = sdaM & ~bus.sda_oe;
  assign bus.rd_data = rdDataQ;

  always @(posedge clk) rdDataQ <= bus.rd_addr[7:0];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wrLog.push_back({bus.wr_addr, bus.wr_data});
      if (wrPrev) wrWide++;
    end
    wrPrev = bus.wr_en;
    if (bus.sda_oe) oeCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    sdaM = 1'b1; sclM = 1'b1; waitCycles(Q);
    sdaM = 1'b0; waitCycles(Q);
    sclM = 1'b0; waitCycles(Q);
  endtask

  task automatic i2cRestart();
    sdaM = 1'b1; waitCycles(Q);
    sclM = 1'b1; waitCycles(Q);
    sdaM = 1'b0; waitCycles(Q);
    sclM = 1'b0; waitCycles(Q);
  endtask

  task automatic i2cStop();
    sdaM = 1'b0; waitCycles(Q);
    sclM = 1'b1; waitCycles(Q);
    sdaM = 1'b1; waitCycles(Q);
  endtask

  task automatic sendBit(input logic b);
    sdaM = b; waitCycles(Q);
    sclM = 1'b1; waitCycles(2 * Q);
    sclM = 1'b0; waitCycles(Q);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    sdaM = 1'b1; waitCycles(Q);
    sclM = 1'b1; waitCycles(Q);
    ack = bus.sda_in;
    waitCycles(Q);
    sclM = 1'b0; waitCycles(Q);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    sdaM = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      waitCycles(Q);
      sclM = 1'b1; waitCycles(Q);
      d[i] = bus.sda_in;
      waitCycles(Q);
      sclM = 1'b0;
    end
    waitCycles(Q);
    sendBit(nack);
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] bytes[], output logic [7:0] nacks);
    logic a;
    nacks = 8'h00;
    for (int i = 0; i < bytes.size(); i++) begin
      writeByte(bytes[i], a);
      checkOutput($sformatf("%s_ack%0d", tag, i), {31'd0, a}, 32'd0);
      nacks[i] = a;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] nk;
    int         oeBase;
    int         logBase;

    waitCycles(4);
    checkOutput("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("rst_wr_addr", {16'd0, bus.wr_addr}, 32'd0);
    checkOutput("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    checkOutput("rst_rd_addr", {16'd0, bus.rd_addr}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    waitCycles(10);

    // Single write of 0xAB to 0x1234
    i2cStart();
    applyStimulus("w1", '{8'h78, 8'h12, 8'h34, 8'hAB}, nk);
    checkOutput("w1_busy", {31'd0, bus.busy}, 32'd1);
    i2cStop();
    checkOutput("w1_busy_after_stop", {31'd0, bus.busy}, 32'd0);
    checkOutput("w1_count", wrLog.size(), 32'd1);
    if (wrLog.size() >= 1) checkOutput("w1_entry", {8'd0, wrLog[0]}, 32'h1234AB);
    checkOutput("w1_rd_addr", {16'd0, bus.rd_addr}, 32'h1235);

    // Burst write across the address wrap
    i2cStart();
    applyStimulus("w2", '{8'h78, 8'hFF, 8'hFF, 8'h01, 8'h02}, nk);
    i2cStop();
    checkOutput("w2_count", wrLog.size(), 32'd3);
    if (wrLog.size() >= 3) begin
      checkOutput("w2_entry0", {8'd0, wrLog[1]}, 32'hFFFF01);
      checkOutput("w2_entry1", {8'd0, wrLog[2]}, 32'h000002);
    end
    checkOutput("w2_rd_addr", {16'd0, bus.rd_addr}, 32'h0001);

    // Foreign device address is ignored
    oeBase = oeCount;
    i2cStart();
    writeByte(8'h42, ack);
    checkOutput("mis_nack", {31'd0, ack}, 32'd1);
    checkOutput("mis_busy", {31'd0, bus.busy}, 32'd0);
    i2cStop();
    checkOutput("mis_oe_seen", oeCount - oeBase, 32'd0);
    checkOutput("mis_count", wrLog.size(), 32'd3);

    // Address write, repeated START, two-byte read
    i2cStart();
    applyStimulus("rd", '{8'h78, 8'h00, 8'h05}, nk);
    i2cRestart();
    writeByte(8'h79, ack);
    checkOutput("rd_dev_ack", {31'd0, ack}, 32'd0);
    readByte(1'b0, d);
    checkOutput("rd_byte0", {24'd0, d}, 32'h05);
    readByte(1'b1, d);
    checkOutput("rd_byte1", {24'd0, d}, 32'h06);
    checkOutput("rd_released", {31'd0, bus.sda_oe}, 32'd0);
    i2cStop();
    checkOutput("rd_count", wrLog.size(), 32'd3);
    checkOutput("rd_rd_addr", {16'd0, bus.rd_addr}, 32'h0006);

    // STOP in the middle of a data byte
    i2cStart();
    applyStimulus("part", '{8'h78, 8'h00, 8'h10}, nk);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
    i2cStop();
    checkOutput("part_count", wrLog.size(), 32'd3);
    checkOutput("part_busy", {31'd0, bus.busy}, 32'd0);
    i2cStart();
    applyStimulus("post", '{8'h78, 8'h00, 8'h20, 8'h5A}, nk);
    i2cStop();
    checkOutput("post_count", wrLog.size(), 32'd4);
    if (wrLog.size() >= 4) checkOutput("post_entry", {8'd0, wrLog[3]}, 32'h00205A);

    // Short SCL/SDA glitch during the low phase must not clock a bit
    i2cStart();
    applyStimulus("gl", '{8'h78, 8'h00, 8'h30}, nk);
    sclM = 1'b1; waitCycles(1);
    sdaM = 1'b0; waitCycles(1);
    sclM = 1'b0; sdaM = 1'b1; waitCycles(Q);
    applyStimulus("gl_data", '{8'hC3}, nk);
    i2cStop();
    logBase = wrLog.size();
    checkOutput("gl_count", logBase, 32'd5);
    if (logBase >= 5) checkOutput("gl_entry", {8'd0, wrLog[4]}, 32'h0030C3);

    // Reset while the target is driving read data (0x31, MSB 0)
    i2cStart();
    writeByte(8'h79, ack);
    checkOutput("rst_rd_ack", {31'd0, ack}, 32'd0);
    checkOutput("rst_rd_driving", {31'd0, bus.sda_oe}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_mid_rd_addr", {16'd0, bus.rd_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitCycles(Q);
    i2cStop();

    checkOutput("wr_en_width", wrWide, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_cfg_slave.md
Name: i2c_cfg_slave

Overview:
- Oversampled I2C/SCCB target (responder) on the 100 MHz domain; the receiving end of the camera configuration I2C master.
- Decodes START, device address, 16-bit register address and data bytes, then issues single-cycle register writes.
- Serves reads from an external register bank with auto-increment.
- Used as the camera-side model in bench and loopback builds, and as a configurable register target in FPGA builds.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit device address this target answers to.
- FILT_LEN, 4, clk_100 cycles a synchronized line must stay stable before its filtered value changes (glitch filter).

Ports:
- clk_100  in  1  system clock, 100 MHz.
- rst_100  in  1  synchronous reset, active-high.
- scl_in  in  1  raw SCL from pad.
- sda_in  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  out  1  one-cycle register write strobe.
- wr_addr  out  16  register address for the write.
- wr_data  out  8  register data for the write.
- rd_addr  out  16  current register address for reads.
- rd_data  in  8  register contents at rd_addr; valid 1 cycle after rd_addr changes.
- busy  out  1  1 from an addressed START until STOP.

Behaviour:
- Reset values:
  - sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0.
  - State IDLE; filtered lines = 1.
- Input conditioning:
  - 2-flop synchronizer on each line, then a FILT_LEN stability filter.
  - Edges are detected on the filtered lines only.
- Bus events:
  - START = filtered SDA falls while SCL=1.
  - STOP = filtered SDA rises while SCL=1.
  - Data is sampled on the SCL rising edge, MSB first.
  - sda_oe changes only on the SCL falling edge.
- States: IDLE, DEV, DEV_ACK, RAH, RAH_ACK, RAL, RAL_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK.
- IDLE -> DEV on START.
- DEV: shift in 8 bits.
  - If byte[7:1]==DEV_ADDR: go to DEV_ACK, assert sda_oe on the next SCL fall, set busy.
  - Otherwise return to IDLE and leave sda_oe=0 (NACK).
- DEV_ACK: release sda_oe on the SCL fall that ends the ACK bit.
  - R/W=0 -> RAH.
  - R/W=1 -> RDAT, loading the shift register from rd_data.
- RAH -> RAH_ACK -> RAL -> RAL_ACK: receive the address high byte, then the low byte.
  - rd_addr = {hi, lo}, updated when the low byte completes.
  - Then enter WDAT.
- WDAT: receive 8 bits, then enter WDAT_ACK and ACK.
  - wr_en pulses exactly 1 cycle, 1 clk after the 8th SCL rise.
  - On that pulse: wr_addr=rd_addr, wr_data=byte.
  - rd_addr increments after the pulse (wraps FFFF->0000).
  - Loop back to WDAT.
- RDAT:
  - Drive sda_oe = ~bit on each SCL fall, MSB first.
  - After 8 bits, release SDA and enter RDAT_ACK.
- RDAT_ACK: sample the master's bit on SCL rise.
  - ACK (0): rd_addr += 1, reload from rd_data, go to RDAT.
  - NACK (1): release and wait in IDLE for STOP/START.
- Repeated START in any state:
  - Go to DEV and release sda_oe.
  - rd_addr is kept, so a write-address + Sr + read sequence reads from the written address.
- STOP in any state: IDLE, sda_oe=0, busy=0.
  - A partial byte is discarded; no wr_en is issued.
- START/STOP detection has priority over bit sampling in the same cycle.
- rst_100 mid-transfer: all outputs return to reset values within 1 cycle and the bus is released.
- No clock stretching: SCL is never driven.

Test Plan:
- Write 0x3C<<1|0, 0x12, 0x34, 0xAB, STOP -> ACK on all 4 bytes; one wr_en pulse with wr_addr=0x1234, wr_data=0xAB; busy falls after STOP.
- Burst write at addr 0xFFFF, data 0x01, 0x02 -> wr_en at 0xFFFF/0x01, then 0x0000/0x02.
- Address 0x21 (mismatch), W -> no ACK (sda_oe stays 0), no wr_en, busy=0.
- Write addr 0x0005, Sr, 0x79 read; model returns rd_data=addr[7:0] -> reads 0x05 (ACK) then 0x06 (NACK); SDA released after NACK.
- STOP after 4 bits of a data byte -> no wr_en, state IDLE; next transaction completes normally.
- 2-cycle glitch on SCL while SDA toggles, FILT_LEN=4 -> no false START/bit; assert rst_100 mid-read -> sda_oe=0 next cycle.
